// File: rtl/gpu_mem_req_queue.sv
// Post-translation shader memory request queue: first-word fall-through FIFO toward memory,
// with faulting requests diverted into a sticky, software-clearable fault record.
module gpu_mem_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR_WIDTH-1:0]        i_req_addr,
  input  logic                         i_req_error,
  input  logic                         i_req_we,
  input  logic [DATA_WIDTH-1:0]        i_req_wdata,
  input  logic [TAG_WIDTH-1:0]         i_req_tag,
  output logic                         o_mem_valid,
  input  logic                         i_mem_ready,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic                         o_mem_we,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  output logic [TAG_WIDTH-1:0]         o_mem_tag,
  output logic                         o_fault_valid,
  output logic [ADDR_WIDTH-1:0]        o_fault_addr,
  output logic [TAG_WIDTH-1:0]         o_fault_tag,
  output logic [7:0]                   o_fault_count,
  input  logic                         i_fault_clear,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [TAG_WIDTH-1:0]  tag;
  } mem_req_t;

  mem_req_t       mem [DEPTH];
  mem_req_t       in_req;
  mem_req_t       head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           xfer, push, pop, fault;

  assign o_full      = (count == CW'(DEPTH));
  assign o_empty     = (count == '0);
  assign o_count     = count;
  // Ready depends only on registered occupancy, so a full queue stays
  // closed for the pop cycle and reopens on the following one.
  assign o_req_ready = !o_full;

  assign xfer  = i_req_valid & o_req_ready;
  assign push  = xfer & !i_req_error;
  assign fault = xfer &  i_req_error;
  assign pop   = o_mem_valid & i_mem_ready;

  assign in_req = '{addr: i_req_addr, we: i_req_we, wdata: i_req_wdata, tag: i_req_tag};

  assign head        = mem[rd_ptr];
  assign o_mem_valid = !o_empty;
  assign o_mem_addr  = head.addr;
  assign o_mem_we    = head.we;
  assign o_mem_wdata = head.wdata;
  assign o_mem_tag   = head.tag;

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A fault arriving with a clear starts a fresh record rather than being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fault_valid <= 1'b0;
      o_fault_addr  <= '0;
      o_fault_tag   <= '0;
      o_fault_count <= '0;
    end else if (fault && (!o_fault_valid || i_fault_clear)) begin
      o_fault_valid <= 1'b1;
      o_fault_addr  <= i_req_addr;
      o_fault_tag   <= i_req_tag;
      o_fault_count <= 8'd1;
    end else if (fault) begin
      if (o_fault_count != 8'hFF) o_fault_count <= o_fault_count + 8'd1;
    end else if (i_fault_clear) begin
      o_fault_valid <= 1'b0;
      o_fault_count <= '0;
    end
  end

endmodule

// File: tb/tb_gpu_mem_req_queue.sv
// Scoreboard bench for gpu_mem_req_queue: accepted good requests are queued as expectations
// and compared against each memory-side pop; fault record and occupancy checked directly.
module tb_gpu_mem_req_queue;
  localparam int AW = 32, DW = 32, TW = 4, DEPTH = 8;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 0, rst_n = 0;
  logic          i_req_valid = 0, i_req_error = 0, i_req_we = 0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0;
  logic [TW-1:0] i_req_tag = '0;
  logic          i_mem_ready = 0, i_fault_clear = 0;
  logic          o_req_ready, o_mem_valid, o_mem_we, o_fault_valid, o_full, o_empty;
  logic [AW-1:0] o_mem_addr, o_fault_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [TW-1:0] o_mem_tag, o_fault_tag;
  logic [7:0]    o_fault_count;
  logic [CW-1:0] o_count;

  gpu_mem_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_error(i_req_error), .i_req_we(i_req_we), .i_req_wdata(i_req_wdata), .i_req_tag(i_req_tag),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .o_mem_tag(o_mem_tag),
    .o_fault_valid(o_fault_valid), .o_fault_addr(o_fault_addr), .o_fault_tag(o_fault_tag),
    .o_fault_count(o_fault_count), .i_fault_clear(i_fault_clear),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0, n_pop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop check runs before the push record; a same-cycle push cannot be the head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_mem_valid && i_mem_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("mem_addr",  o_mem_addr,  e.addr);
          chk("mem_we",    o_mem_we,    e.we);
          chk("mem_wdata", o_mem_wdata, e.wdata);
          chk("mem_tag",   o_mem_tag,   e.tag);
          n_pop++;
        end
      end
      if (i_req_valid && o_req_ready && !i_req_error)
        sb.push_back('{addr: i_req_addr, we: i_req_we, wdata: i_req_wdata, tag: i_req_tag});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                       input logic [TW-1:0] t, input logic err);
    i_req_valid = 1; i_req_addr = a; i_req_we = we; i_req_wdata = d; i_req_tag = t; i_req_error = err;
  endtask

  task automatic idle();
    i_req_valid = 0; i_req_error = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    i_mem_ready = 1;
    while (!o_empty && n < 50) begin tick(); n++; end
    chk(tag, o_empty, 1);
    chk({tag, "_sb"}, sb.size(), 0);
    i_mem_ready = 0;
  endtask

  initial begin
    int pops0;
    #12 rst_n = 1;
    tick();
    // reset / idle
    chk("rst_empty", o_empty, 1);
    chk("rst_ready", o_req_ready, 1);
    chk("rst_mvalid", o_mem_valid, 0);
    chk("rst_full", o_full, 0);
    chk("rst_fvalid", o_fault_valid, 0);
    chk("rst_fcount", o_fault_count, 0);
    chk("rst_maddr", o_mem_addr, 0);

    // three reads held back, then released in order
    for (int i = 0; i < 3; i++) begin drive(32'h100 + 4*i, 0, 0, TW'(i+1), 0); tick(); end
    idle();
    chk("three_count", o_count, 3);
    chk("three_head", o_mem_addr, 32'h100);
    drain("three_drain");

    // fill, blocked 9th, reopen after one pop
    for (int i = 0; i < DEPTH; i++) begin drive(32'h1000 + 4*i, 1, 32'hA000_0000 + i, TW'(i), 0); tick(); end
    chk("fill_full", o_full, 1);
    chk("fill_ready", o_req_ready, 0);
    drive(32'h1FF0, 1, 32'hBEEF, 4'hF, 0);
    tick();
    chk("ninth_blocked", o_count, DEPTH);
    i_mem_ready = 1;
    tick();
    i_mem_ready = 0;
    chk("pop_count", o_count, DEPTH-1);
    chk("pop_ready", o_req_ready, 1);
    tick();
    idle();
    chk("ninth_accepted", o_count, DEPTH);
    drain("fill_drain");

    // streaming through pointer wrap
    pops0 = n_pop;
    i_mem_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drive(32'h8000 + 16*i, i[0], 32'h5500 + i, TW'(i), 0);
      tick();
      chk("stream_occ", o_count, 1);
    end
    idle();
    tick();
    i_mem_ready = 0;
    chk("stream_pops", n_pop - pops0, 20);
    chk("stream_empty", o_empty, 1);

    // fault record
    drive(32'h2000, 0, 0, 4'd5, 1); tick();
    drive(32'h3000, 0, 0, 4'd6, 1); tick();
    drive(32'h4000, 0, 0, 4'd8, 1); tick();
    idle();
    chk("flt_valid", o_fault_valid, 1);
    chk("flt_addr", o_fault_addr, 32'h2000);
    chk("flt_tag", o_fault_tag, 5);
    chk("flt_count", o_fault_count, 3);
    chk("flt_fifo", o_count, 0);
    for (int i = 0; i < 300; i++) begin drive(32'h6000 + i, 0, 0, 4'd1, 1); tick(); end
    idle();
    chk("flt_sat", o_fault_count, 255);
    chk("flt_sat_addr", o_fault_addr, 32'h2000);

    // clear coinciding with a fault, then clear alone
    drive(32'h5000, 0, 0, 4'd7, 1); i_fault_clear = 1; tick();
    idle(); i_fault_clear = 0;
    chk("clrf_valid", o_fault_valid, 1);
    chk("clrf_addr", o_fault_addr, 32'h5000);
    chk("clrf_tag", o_fault_tag, 7);
    chk("clrf_count", o_fault_count, 1);
    i_fault_clear = 1; tick(); i_fault_clear = 0;
    chk("clr_valid", o_fault_valid, 0);
    chk("clr_count", o_fault_count, 0);
    chk("clr_addr_hold", o_fault_addr, 32'h5000);

    // asynchronous reset with entries queued
    for (int i = 0; i < 4; i++) begin drive(32'h7000 + 4*i, 0, 0, TW'(i), 0); tick(); end
    idle();
    chk("pre_rst_count", o_count, 4);
    #2 rst_n = 0;
    #1;
    chk("arst_count", o_count, 0);
    chk("arst_mvalid", o_mem_valid, 0);
    chk("arst_ready", o_req_ready, 1);
    sb.delete();
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_empty", o_empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/gpu_mem_req_queue.md
Name: gpu_mem_req_queue

Overview:
- Sits directly downstream of the GPU address-translation stage. Accepts translated shader memory requests, each carrying a physical address and a translation-error flag.
- Buffers good requests in a FIFO and issues them to the memory interface over a valid/ready handshake.
- Diverts faulting requests into a sticky fault-status record that software can read and clear.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- DATA_WIDTH, 32, write-data width.
- TAG_WIDTH, 4, request tag (thread/warp id) width.
- DEPTH, 8, FIFO entries. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  upstream request present (good or faulting)
- o_req_ready  out  1  queue can accept a request this cycle
- i_req_addr  in  ADDR_WIDTH  translated physical address
- i_req_error  in  1  translation fault for this request
- i_req_we  in  1  1=write, 0=read
- i_req_wdata  in  DATA_WIDTH  write data
- i_req_tag  in  TAG_WIDTH  request tag
- o_mem_valid  out  1  request at FIFO head valid toward memory
- i_mem_ready  in  1  memory accepts head request
- o_mem_addr  out  ADDR_WIDTH  head address
- o_mem_we  out  1  head write flag
- o_mem_wdata  out  DATA_WIDTH  head write data
- o_mem_tag  out  TAG_WIDTH  head tag
- o_fault_valid  out  1  sticky: at least one fault logged since last clear
- o_fault_addr  out  ADDR_WIDTH  address of first logged fault
- o_fault_tag  out  TAG_WIDTH  tag of first logged fault
- o_fault_count  out  8  faults since last clear, saturating at 255
- i_fault_clear  in  1  single-cycle pulse clearing the fault record
- o_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- o_full  out  1  occupancy == DEPTH
- o_empty  out  1  occupancy == 0

Behaviour:

Reset:
- rst_n low asynchronously empties the FIFO (pointers and count = 0) and clears the fault record.
- Reset values: o_mem_valid=0, o_count=0, o_empty=1, o_full=0, o_req_ready=1, o_fault_valid=0, o_fault_count=0, o_fault_addr=0, o_fault_tag=0.
- o_mem_addr/we/wdata/tag read 0 after reset.
- Reset asserted mid-operation drops all queued requests. No request is reissued.

Upstream handshake:
- Transfer occurs when i_req_valid & o_req_ready.
- o_req_ready = !o_full, computed from registered state only. No combinational path from i_mem_ready.
- On transfer with i_req_error=0: {addr, we, wdata, tag} written at the write pointer; write pointer and count advance.
- On transfer with i_req_error=1: nothing enqueued; the fault record is updated. Faulting requests still require o_req_ready.

Downstream handshake:
- First-word fall-through: o_mem_valid = !o_empty, and o_mem_* reflect the head entry directly from storage.
- A request accepted in cycle N appears on o_mem_valid in cycle N+1 if the FIFO was empty (latency 1).
- Pop occurs when o_mem_valid & i_mem_ready; the read pointer advances.
- While o_mem_valid=1 and i_mem_ready=0, all o_mem_* stay stable.

Occupancy:
- Simultaneous push and pop: count unchanged, both pointers advance. Allowed at any non-full occupancy, including empty→push only. Pop is impossible when empty.
- When full, push is blocked even if a pop occurs the same cycle; ready re-asserts the cycle after the pop.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- o_full and o_empty are derived from count.

Fault record:
- Fault with o_fault_valid=0: capture addr/tag, set o_fault_valid=1, set count=1.
- Fault with o_fault_valid=1: addr/tag hold; count increments, saturating at 255.
- i_fault_clear with no fault that cycle: o_fault_valid=0, count=0, addr/tag hold their old values.
- i_fault_clear in the same cycle as a fault: the new fault is captured as first, count=1, valid=1.
- Fault logging is independent of FIFO state.

Test Plan:
- Reset then idle: o_empty=1, o_req_ready=1, o_mem_valid=0, o_fault_valid=0, o_fault_count=0.
- Push 3 good reads (addr 0x100, 0x104, 0x108, tags 1, 2, 3) with i_mem_ready=0: o_count=3. Raise ready: o_mem_addr 0x100, 0x104, 0x108 on consecutive cycles, then o_empty=1.
- Fill with DEPTH=8 writes, i_mem_ready=0: o_full=1, o_req_ready=0, the 9th request is not accepted. Pop one: o_req_ready=1 on the next cycle and the 9th is accepted.
- Continuous push and pop with ready=1 for 20 requests: occupancy stays 1. Addresses emerge in order across pointer wrap with no loss or duplication.
- Fault at 0x2000 tag 5, then faults at 0x3000 and 0x4000: o_fault_addr=0x2000, tag=5, count=3, FIFO unchanged. Apply 300 faults: count saturates at 255.
- i_fault_clear same cycle as fault at 0x5000 tag 7: valid=1, addr=0x5000, tag=7, count=1.
- Assert rst_n low with 4 entries queued: o_count=0 and o_mem_valid=0 immediately (asynchronously).
